// File: rtl/axon_spike_scheduler.sv
// -----------------------------------------------------------------------------
// axon_spike_scheduler
//
// Purpose:
//   Gathers incoming axon spikes into a capture bitmap during one timestep.
//   On each tick it swaps that bitmap into a process bitmap. It then walks the
//   process bitmap in ascending axon order. Each set axon is presented to the
//   synapse_connection block, and every connected-neuron event returned for it
//   is forwarded to the neuron update block one cycle later.
//
// Ports:
//   clk, rst               rising-edge clock; synchronous active-high reset
//   spike_in_valid/_axon   incoming axon spike (sets a capture-bank bit)
//   tick                   timestep strobe; starts processing the captured bank
//   syn_enable             one-cycle request to synapse_connection
//   syn_axon_number        axon being presented; stable until syn_done
//   syn_neuron_valid/_number  connected-neuron events from synapse_connection
//   syn_done               synapse_connection finished the current axon
//   out_valid/out_neuron   registered neuron event towards the neuron block
//   busy                   high while a timestep is being processed
//   step_done              one-cycle pulse when the timestep is complete
//   tick_overrun           sticky: a tick arrived while busy (cleared by rst)
//   spike_count            (only with AXON_SPIKE_SCHED_STATS_EN) axons issued
//                          in the current step
//
// Optional feature macro: AXON_SPIKE_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module axon_spike_scheduler #(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             spike_in_valid,
    input  logic [$clog2(NUM_AXONS)-1:0]     spike_in_axon,
    input  logic                             tick,
    output logic                             syn_enable,
    output logic [$clog2(NUM_AXONS)-1:0]     syn_axon_number,
    input  logic                             syn_neuron_valid,
    input  logic [$clog2(NUM_NEURONS)-1:0]   syn_neuron_number,
    input  logic                             syn_done,
    output logic                             out_valid,
    output logic [$clog2(NUM_NEURONS)-1:0]   out_neuron,
    output logic                             busy,
    output logic                             step_done,
    output logic                             tick_overrun
`ifdef AXON_SPIKE_SCHED_STATS_EN
    ,
    output logic [$clog2(NUM_AXONS):0]       spike_count
`endif
);

    localparam int AW = $clog2(NUM_AXONS);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_AXONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_AXONS-1:0]  cap_q, cap_d;
    logic [NUM_AXONS-1:0]  proc_q, proc_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [NW-1:0]         out_neuron_q, out_neuron_d;
    logic                  overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        proc_d       = proc_q;
        idx_d        = idx_q;
        out_valid_d  = 1'b0;
        out_neuron_d = out_neuron_q;
        overrun_d    = overrun_q;
        syn_enable   = 1'b0;
        step_done    = 1'b0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (tick) begin
                    // Swap banks: the bank just captured is processed, the
                    // capture bank restarts empty.
                    proc_d  = cap_q;
                    cap_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (proc_q[idx_q]) begin
                    state_d = ISSUE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ISSUE: begin
                syn_enable     = 1'b1;
                proc_d[idx_q]  = 1'b0;
                state_d        = WAIT;
            end
            WAIT: begin
                // A neuron event coincident with syn_done is still forwarded.
                if (syn_neuron_valid) begin
                    out_valid_d  = 1'b1;
                    out_neuron_d = syn_neuron_number;
                end
                if (syn_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = SCAN;
                    end
                end
            end
            FINISH: begin
                step_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Applied after the swap so a spike arriving with tick lands in the
        // freshly cleared capture bank.
        if (spike_in_valid) begin
            cap_d[spike_in_axon] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cap_q        <= '0;
            proc_q       <= '0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_neuron_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            proc_q       <= proc_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            out_neuron_q <= out_neuron_d;
            overrun_q    <= overrun_d;
        end
    end

    // The scan index is held from ISSUE through WAIT, so it doubles as the
    // presented axon number.
    assign syn_axon_number = idx_q;
    assign out_valid       = out_valid_q;
    assign out_neuron      = out_neuron_q;
    assign tick_overrun    = overrun_q;

`ifdef AXON_SPIKE_SCHED_STATS_EN
    logic [AW:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if ((state_q == IDLE) && tick) begin
            count_d = '0;
        end else if (state_q == ISSUE) begin
            count_d = count_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign spike_count = count_q;
`endif

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// -----------------------------------------------------------------------------
// tb_axon_spike_scheduler
//
// Purpose:
//   Self-checking bench for axon_spike_scheduler (default parameters).
//   A timing model predicts each output cycle by cycle. It tracks the set of
//   captured and pending axons, the index the scan has reached and the cycle
//   at which that index is examined. From these it computes the cycle of each
//   syn_enable and of step_done. The bench also plays the synapse_connection
//   block and checks a few scenarios against hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_axon_spike_scheduler;

    localparam int N  = 256;
    localparam int AW = 8;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spike_in_valid = 1'b0;
    logic [AW-1:0] spike_in_axon = '0;
    logic          tick = 1'b0;
    logic          syn_enable;
    logic [AW-1:0] syn_axon_number;
    logic          syn_neuron_valid = 1'b0;
    logic [NW-1:0] syn_neuron_number = '0;
    logic          syn_done = 1'b0;
    logic          out_valid;
    logic [NW-1:0] out_neuron;
    logic          busy;
    logic          step_done;
    logic          tick_overrun;
`ifdef AXON_SPIKE_SCHED_STATS_EN
    logic [AW:0]   spike_count;
`endif

    always #5 clk = ~clk;

    axon_spike_scheduler #(.NUM_AXONS(N), .NUM_NEURONS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .spike_in_valid    (spike_in_valid),
        .spike_in_axon     (spike_in_axon),
        .tick              (tick),
        .syn_enable        (syn_enable),
        .syn_axon_number   (syn_axon_number),
        .syn_neuron_valid  (syn_neuron_valid),
        .syn_neuron_number (syn_neuron_number),
        .syn_done          (syn_done),
        .out_valid         (out_valid),
        .out_neuron        (out_neuron),
        .busy              (busy),
        .step_done         (step_done),
        .tick_overrun      (tick_overrun)
`ifdef AXON_SPIKE_SCHED_STATS_EN
        ,
        .spike_count       (spike_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          v;
        logic [NW-1:0] n;
        logic          d;
    } resp_t;

    resp_t plan[$];   // synapse responses for the upcoming cycles
    resp_t dir_q[$];  // directed response used for the next issued axon
    bit    noise_en = 1'b0;

    // Behavioural model state
    bit         model_on = 1'b0;
    bit         busy_m   = 1'b0;
    bit         in_wait  = 1'b0;
    bit         ovr_m    = 1'b0;
    bit         chk_rst  = 1'b0;
    bit         exp_ov   = 1'b0;
    logic [NW-1:0] exp_on = '0;
    bit [N-1:0] cap_m  = '0;
    bit [N-1:0] proc_m = '0;
    int         pos = 0;     // next axon index still to be scanned
    int         t0  = 0;     // cycle in which index pos is scanned
    int         cur = 0;     // axon currently waiting for syn_done
    int         count_m = 0;

    // Event logs for the literal scenario checks
    int log_ax[$];
    int log_ax_cyc[$];
    int log_on[$];
    int log_on_cyc[$];
    int sd_cyc = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int next_set(input int from);
        for (int i = from; i < N; i++) begin
            if (proc_m[i]) return i;
        end
        return -1;
    endfunction

    task automatic make_plan();
        resp_t e;
        int    n;
        bit    coinc;
        if (dir_q.size() > 0) begin
            plan = dir_q;
            dir_q.delete();
        end else begin
            n     = $urandom_range(0, 3);
            coinc = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < n; k++) begin
                e = '0;
                repeat ($urandom_range(0, 2)) plan.push_back(e);
                e.v = 1'b1;
                e.n = NW'($urandom);
                e.d = (k == n - 1) && coinc;
                plan.push_back(e);
            end
            if (!(n > 0 && coinc)) begin
                e = '0;
                repeat ($urandom_range(0, 2)) plan.push_back(e);
                e.d = 1'b1;
                plan.push_back(e);
            end
        end
    endtask

    // Compare process: checks this cycle's outputs, then folds this cycle's
    // inputs into the model.
    always @(negedge clk) begin : cmp
        int nxt;
        bit en_x, sd_x, w_now, b_now;
        en_x = 1'b0;
        sd_x = 1'b0;
        nxt  = -1;
        if (model_on) begin
            if (busy_m && !in_wait) begin
                nxt = next_set(pos);
                if (nxt >= 0) en_x = (cyc == t0 + (nxt - pos) + 1);
                else          sd_x = (cyc == t0 + (N - pos));
            end
            chk("syn_enable", syn_enable, en_x);
            chk("step_done", step_done, sd_x);
            chk("busy", busy, busy_m);
            chk("tick_overrun", tick_overrun, ovr_m);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) chk("out_neuron", out_neuron, exp_on);
            if (en_x)    chk("syn_axon_number", syn_axon_number, nxt);
            if (in_wait) chk("syn_axon_hold", syn_axon_number, cur);
            if (chk_rst) begin
                chk("rst_syn_axon_number", syn_axon_number, 0);
                chk("rst_out_neuron", out_neuron, 0);
            end
`ifdef AXON_SPIKE_SCHED_STATS_EN
            chk("spike_count", spike_count, count_m);
`endif
            if (syn_enable === 1'b1) begin
                log_ax.push_back(int'(syn_axon_number));
                log_ax_cyc.push_back(cyc);
            end
            if (out_valid === 1'b1) begin
                log_on.push_back(int'(out_neuron));
                log_on_cyc.push_back(cyc);
            end
            if (step_done === 1'b1) sd_cyc = cyc;
        end

        w_now = in_wait;
        b_now = busy_m;
        if (en_x) begin
            in_wait     = 1'b1;
            cur         = nxt;
            proc_m[nxt] = 1'b0;
            count_m++;
            make_plan();
        end
        if (sd_x) busy_m = 1'b0;

        if (rst) begin
            model_on = 1'b1;
            busy_m   = 1'b0;
            in_wait  = 1'b0;
            ovr_m    = 1'b0;
            chk_rst  = 1'b1;
            exp_ov   = 1'b0;
            cap_m    = '0;
            proc_m   = '0;
            pos      = 0;
            count_m  = 0;
            plan.delete();
        end else if (model_on) begin
            chk_rst = 1'b0;
            exp_ov  = w_now && syn_neuron_valid;
            exp_on  = syn_neuron_number;
            if (w_now && syn_done) begin
                in_wait = 1'b0;
                pos     = cur + 1;
                t0      = cyc + 1;
            end
            if (tick) begin
                if (b_now) begin
                    ovr_m = 1'b1;
                end else begin
                    proc_m  = cap_m;
                    cap_m   = '0;
                    pos     = 0;
                    t0      = cyc + 1;
                    busy_m  = 1'b1;
                    count_m = 0;
                end
            end
            if (spike_in_valid) cap_m[spike_in_axon] = 1'b1;
        end
    end

    task automatic drive(input bit r, input bit tk, input bit sv, input int sa);
        resp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        tick           = tk;
        spike_in_valid = sv;
        spike_in_axon  = AW'(sa);
        if (plan.size() > 0) begin
            e = plan.pop_front();
            syn_neuron_valid  = e.v;
            syn_neuron_number = e.n;
            syn_done          = e.d;
        end else begin
            syn_neuron_valid  = noise_en && ($urandom_range(0, 5) == 0);
            syn_neuron_number = NW'($urandom);
            syn_done          = noise_en && ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic rnd_cycle();
        int r;
        r = $urandom_range(0, 99);
        if (r < 6)       drive(1'b0, 1'b0, 1'b1, $urandom_range(0, N - 1));
        else if (r == 6) drive(1'b0, 1'b1, 1'b0, 0);
        else             idle();
    endtask

    task automatic clear_logs();
        log_ax.delete();
        log_ax_cyc.delete();
        log_on.delete();
        log_on_cyc.delete();
        sd_cyc = -1;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n;
        if (rnd) rnd_cycle(); else idle();
        n = 1;
        while (busy_m && n < budget) begin
            if (rnd) rnd_cycle(); else idle();
            n++;
        end
        if (busy_m) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: step not finished after %0d cycles", budget);
            drive(1'b1, 1'b0, 1'b0, 0);
            drive(1'b1, 1'b0, 1'b0, 0);
            idle();
        end
    endtask

    task automatic wait_for_wait(input string nm);
        int n;
        n = 0;
        while (!in_wait && n < 600) begin
            idle();
            n++;
        end
        chk(nm, in_wait, 1);
    endtask

    task automatic long_response();
        resp_t e;
        e = '0;
        repeat (5) dir_q.push_back(e);
        e.d = 1'b1;
        dir_q.push_back(e);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        resp_t e;
        int    tc;

        repeat (3) drive(1'b1, 1'b0, 1'b0, 0);
        idle();
        chk("reset_busy", busy, 0);
        chk("reset_syn_enable", syn_enable, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_step_done", step_done, 0);
        chk("reset_tick_overrun", tick_overrun, 0);
        chk("reset_syn_axon_number", syn_axon_number, 0);
        chk("reset_out_neuron", out_neuron, 0);

        // Duplicate spikes are idempotent: axons 3 and 200, issued once each.
        clear_logs();
        drive(1'b0, 1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 1'b1, 200);
        drive(1'b0, 1'b1, 1'b0, 0);
        wait_idle(2000, 1'b0);
        chk("dup_issue_count", log_ax.size(), 2);
        if (log_ax.size() == 2) begin
            chk("dup_first_axon", log_ax[0], 3);
            chk("dup_second_axon", log_ax[1], 200);
        end
        chk("dup_step_done_seen", (sd_cyc >= 0), 1);

        // Empty bank: step_done NUM_AXONS+1 = 257 cycles after tick.
        clear_logs();
        drive(1'b0, 1'b1, 1'b0, 0);
        tc = cyc;
        wait_idle(2000, 1'b0);
        chk("empty_latency", sd_cyc - tc, 257);
        chk("empty_no_issue", log_ax.size(), 0);

        // Axon 5, neurons 0, 7, 255 back-to-back, last with syn_done.
        e = '0; e.v = 1'b1; e.n = 8'd0;   dir_q.push_back(e);
        e = '0; e.v = 1'b1; e.n = 8'd7;   dir_q.push_back(e);
        e = '0; e.v = 1'b1; e.n = 8'd255; e.d = 1'b1; dir_q.push_back(e);
        clear_logs();
        drive(1'b0, 1'b0, 1'b1, 5);
        drive(1'b0, 1'b1, 1'b0, 0);
        wait_idle(2000, 1'b0);
        chk("fwd_issue_count", log_ax.size(), 1);
        chk("fwd_out_count", log_on.size(), 3);
        if (log_ax.size() == 1 && log_on.size() == 3) begin
            chk("fwd_axon", log_ax[0], 5);
            chk("fwd_neuron0", log_on[0], 0);
            chk("fwd_neuron1", log_on[1], 7);
            chk("fwd_neuron2", log_on[2], 255);
            for (int i = 0; i < 3; i++) chk("fwd_latency", log_on_cyc[i] - log_ax_cyc[0], i + 2);
        end

        // Spike in the tick cycle belongs to the next step.
        clear_logs();
        drive(1'b0, 1'b1, 1'b1, 10);
        wait_idle(2000, 1'b0);
        chk("late_spike_step1", log_ax.size(), 0);
        clear_logs();
        drive(1'b0, 1'b1, 1'b0, 0);
        wait_idle(2000, 1'b0);
        chk("late_spike_step2_count", log_ax.size(), 1);
        if (log_ax.size() == 1) chk("late_spike_step2_axon", log_ax[0], 10);

        // Tick during WAIT: overrun flagged, step finishes, no swap.
        clear_logs();
        long_response();
        drive(1'b0, 1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 1'b1, 30);
        drive(1'b0, 1'b1, 1'b0, 0);
        wait_for_wait("overrun_reach_wait");
        drive(1'b0, 1'b1, 1'b1, 40);
        wait_idle(2000, 1'b0);
        chk("overrun_flag", tick_overrun, 1);
        chk("overrun_issue_count", log_ax.size(), 2);
        if (log_ax.size() == 2) begin
            chk("overrun_axon0", log_ax[0], 20);
            chk("overrun_axon1", log_ax[1], 30);
        end
        clear_logs();
        drive(1'b0, 1'b1, 1'b0, 0);
        wait_idle(2000, 1'b0);
        chk("overrun_next_count", log_ax.size(), 1);
        if (log_ax.size() == 1) chk("overrun_next_axon", log_ax[0], 40);

        // rst in WAIT, then a clean restart with axon 1 only.
        long_response();
        drive(1'b0, 1'b0, 1'b1, 50);
        drive(1'b0, 1'b1, 1'b0, 0);
        wait_for_wait("rst_reach_wait");
        drive(1'b1, 1'b0, 1'b0, 0);
        clear_logs();
        drive(1'b0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b1, 1'b0, 0);
        wait_idle(2000, 1'b0);
        chk("restart_issue_count", log_ax.size(), 1);
        if (log_ax.size() == 1) chk("restart_axon", log_ax[0], 1);
        chk("restart_overrun_cleared", tick_overrun, 0);
`ifdef AXON_SPIKE_SCHED_STATS_EN
        chk("restart_spike_count", spike_count, 1);
`endif

        // Randomised steps with noise outside WAIT and stray ticks.
        noise_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 12)) begin
                case ($urandom_range(0, 3))
                    0:       drive(1'b0, 1'b0, 1'b1, 0);
                    1:       drive(1'b0, 1'b0, 1'b1, N - 1);
                    default: drive(1'b0, 1'b0, 1'b1, $urandom_range(0, N - 1));
                endcase
            end
            drive(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, N - 1));
            wait_idle(3000, 1'b1);
        end
        noise_en = 1'b0;
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axon_spike_scheduler.md
AXON_SPIKE_SCHEDULER -- requirements
Module: axon_spike_scheduler

Interface
REQ-001 Parameter NUM_AXONS, default 256: number of axons; AW = $clog2(NUM_AXONS).
REQ-002 Parameter NUM_NEURONS, default 256: number of neurons; NW = $clog2(NUM_NEURONS).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 spike_in_valid  input  1  incoming axon spike strobe.
REQ-006 spike_in_axon  input  AW  axon index of the incoming spike.
REQ-007 tick  input  1  one-cycle timestep strobe; starts processing of the previous step's spikes.
REQ-008 syn_enable  output  1  request to the synapse_connection block.
REQ-009 syn_axon_number  output  AW  axon currently presented to the synapse_connection block.
REQ-010 syn_neuron_valid  input  1  connected-neuron strobe from synapse_connection.
REQ-011 syn_neuron_number  input  NW  connected-neuron index from synapse_connection.
REQ-012 syn_done  input  1  synapse_connection finished the current axon.
REQ-013 out_valid / out_neuron  output  1 / NW  forwarded neuron event to the neuron update block.
REQ-014 busy  output  1  timestep processing in progress.
REQ-015 step_done  output  1  one-cycle pulse when all spikes of a timestep are processed.
REQ-016 tick_overrun  output  1  sticky flag, set when tick arrives while busy.

Function
REQ-017 Two NUM_AXONS-bit spike bitmaps are kept: a capture bank and a process bank; spike_in_valid sets bit spike_in_axon in the capture bank, and duplicate spikes are idempotent.
REQ-018 FSM states are IDLE, SCAN, ISSUE, WAIT, and FINISH.
REQ-019 In IDLE, tick causes a bank swap: the capture bank becomes the process bank, the new capture bank is cleared, a spike arriving in the same cycle lands in the new capture bank, and the FSM goes to SCAN with scan index 0.
REQ-020 SCAN examines one bit per cycle at scan index: if the bit is set, go to ISSUE; if it is clear and the index is NUM_AXONS-1, go to FINISH; if it is clear otherwise, increment the index.
REQ-021 ISSUE drives syn_enable=1 for exactly one cycle with syn_axon_number equal to the scan index, clears that process bit, and goes to WAIT.
REQ-022 syn_axon_number holds stable from ISSUE until syn_done is sampled.
REQ-023 In WAIT, each syn_neuron_valid produces out_valid=1 and out_neuron=syn_neuron_number on the next cycle (1-cycle registered latency) with no drops.
REQ-024 A syn_neuron_valid coincident with syn_done is forwarded.
REQ-025 On syn_done in WAIT, go to FINISH if the scan index is NUM_AXONS-1, else increment the index and return to SCAN; the index never wraps within a step.
REQ-026 FINISH pulses step_done for 1 cycle and returns to IDLE; busy=1 in every state except IDLE.
REQ-027 An empty process bank yields step_done exactly NUM_AXONS+1 cycles after tick.
REQ-028 tick while busy is ignored (no swap) and sets tick_overrun; tick_overrun clears only on rst.
REQ-029 syn_done or syn_neuron_valid outside WAIT is ignored.

Reset
REQ-030 On rst, the FSM goes to IDLE, both bitmaps and the scan index clear, and syn_enable, out_valid, busy, step_done, and tick_overrun are 0, with syn_axon_number=0 and out_neuron=0.
REQ-031 rst mid-step abandons the step with no step_done, and the next out_valid occurs only after a new tick.

Configuration
REQ-032 With macro AXON_SPIKE_SCHED_STATS_EN defined, an output spike_count (AW+1 bits) counts axons issued in the current step, resets to 0 on tick-accept and on rst, and holds its value after step_done.
REQ-033 Without AXON_SPIKE_SCHED_STATS_EN, the spike_count port and counter are absent and all other behaviour is identical.

Verification
REQ-034 Spikes 3, 3, 200 then tick -> syn_enable pulses with axon 3 then 200 (only twice); step_done follows the second syn_done.
REQ-035 No spikes then tick -> no syn_enable; step_done 257 cycles after tick; busy is high throughout.
REQ-036 Axon 5 issued; model returns valid with neurons 0, 7, 255, the last coincident with syn_done -> out_neuron 0, 7, 255, each 1 cycle after its input.
REQ-037 Spike 10 in the same cycle as tick, then a second tick after step_done -> axon 10 is not processed in the first step and is issued in the second step.
REQ-038 tick during WAIT -> tick_overrun=1, the current step completes normally, and the bank is not swapped.
REQ-039 rst asserted in WAIT, then spike 1 and tick -> clean restart with only axon 1 issued; with AXON_SPIKE_SCHED_STATS_EN, spike_count=1 after step_done.
